// File: rtl/pipe_stage_reg.sv
// Purpose: pipeline stage register with valid/ready handshake, optional 2-entry skid, flush and bubble-safe ctrl gating.
// Latency: 1 cycle from in_fire to out_vld when empty; 1 entry/cycle sustained while downstream is ready.
// Backpressure: SKID=1 absorbs one extra entry and drops a registered in_rdy; SKID=0 in_rdy = ~out_vld | out_rdy.
//
// Ports:
//   i_core_clk   rising-edge clock
//   i_rst        synchronous active-high reset (beats flush, flush beats handshake)
//   i_flush      discard every held entry; a same-cycle input is consumed and dropped
//   i_in_vld / o_in_rdy / i_in_dat / i_in_ctrl      upstream handshake and entry
//   o_out_vld / i_out_rdy / o_out_dat / o_out_ctrl  downstream handshake and entry
//   o_occupancy  held entries (0..2, at most 1 when SKID=0)
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              i_core_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_vld,
  output logic              o_in_rdy,
  input  logic [DATA_W-1:0] i_in_dat,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  output logic [DATA_W-1:0] o_out_dat,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [1:0]        o_occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  entry_t     r_main;
  logic       r_out_vld;
  logic [1:0] r_occ;
  entry_t     w_in_ent;
  logic       w_out_fire;

  assign w_in_ent    = '{dat: i_in_dat, ctrl: i_in_ctrl};
  assign w_out_fire  = r_out_vld & i_out_rdy;

  assign o_out_vld   = r_out_vld;
  assign o_out_dat   = r_main.dat;
  assign o_out_ctrl  = r_main.ctrl;
  assign o_occupancy = r_occ;

  if (SKID != 0) begin : g_skid
    state_t     r_state;
    state_t     w_nxt_state;
    entry_t     r_skid;
    logic       r_in_rdy;
    logic       w_in_fire;
    logic       w_ld_main_in;
    logic       w_ld_main_skid;
    logic       w_ld_skid;
    logic       w_clr_ctrl;
    logic [1:0] w_nxt_occ;

    assign w_in_fire = i_in_vld & r_in_rdy;
    assign o_in_rdy  = r_in_rdy;

    always_comb begin
      w_nxt_state    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      w_clr_ctrl     = 1'b0;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_nxt_state  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_ld_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_nxt_state = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_out_fire) begin
            w_nxt_state = ST_EMPTY;
            w_clr_ctrl  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_nxt_state    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: begin
          w_nxt_state = ST_EMPTY;
          w_clr_ctrl  = 1'b1;
        end
      endcase
      // Flush overrides every load; any same-cycle input is swallowed here.
      if (i_flush) begin
        w_nxt_state    = ST_EMPTY;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        w_clr_ctrl     = 1'b1;
      end
      case (w_nxt_state)
        ST_ONE:  w_nxt_occ = 2'd1;
        ST_FULL: w_nxt_occ = 2'd2;
        default: w_nxt_occ = 2'd0;
      endcase
    end

    // Status outputs are registered from the next state so none of them
    // (in particular in_rdy) has a combinational path from out_rdy.
    always_ff @(posedge i_core_clk) begin
      if (i_rst) begin
        r_state   <= ST_EMPTY;
        r_main    <= '0;
        r_skid    <= '0;
        r_out_vld <= 1'b0;
        r_in_rdy  <= 1'b1;
        r_occ     <= 2'd0;
      end else begin
        r_state   <= w_nxt_state;
        r_out_vld <= (w_nxt_state != ST_EMPTY);
        r_in_rdy  <= (w_nxt_state != ST_FULL);
        r_occ     <= w_nxt_occ;
        if (w_ld_main_in) begin
          r_main <= w_in_ent;
        end else if (w_ld_main_skid) begin
          r_main <= r_skid;
        end else if (w_clr_ctrl) begin
          // Payload is left alone so out_dat stays stable while idle.
          r_main.ctrl <= '0;
        end
        if (w_ld_skid) begin
          r_skid <= w_in_ent;
        end else if (i_flush) begin
          r_skid <= '0;
        end
      end
    end
  end else begin : g_reg
    logic w_in_rdy;
    logic w_in_fire;

    assign w_in_rdy  = ~r_out_vld | i_out_rdy;
    assign w_in_fire = i_in_vld & w_in_rdy;
    assign o_in_rdy  = w_in_rdy;

    always_ff @(posedge i_core_clk) begin
      if (i_rst) begin
        r_main    <= '0;
        r_out_vld <= 1'b0;
        r_occ     <= 2'd0;
      end else if (i_flush) begin
        r_out_vld   <= 1'b0;
        r_main.ctrl <= '0;
        r_occ       <= 2'd0;
      end else if (w_in_fire) begin
        r_main    <= w_in_ent;
        r_out_vld <= 1'b1;
        r_occ     <= 2'd1;
      end else if (w_out_fire) begin
        r_out_vld   <= 1'b0;
        r_main.ctrl <= '0;
        r_occ       <= 2'd0;
      end
    end
  end

endmodule
